// File: rtl/ps2_port_fifo.sv
// PS/2 host port: filtered pad inputs, receive framing into a first-word fall-through FIFO,
// host-to-device transmit with request/ack sequencing, a receive bit timeout and a transmit watchdog.
module ps2_port_fifo #(
  parameter int pClkFreq  = 40000000,
  parameter int pRxDepth  = 16,
  parameter int pFiltLen  = 8,
  parameter int p5us      = pClkFreq / 200000,
  parameter int p100us    = pClkFreq / 10000,
  parameter int pRxBitTmo = pClkFreq / 1000,
  parameter int pTxTmo    = pClkFreq / 40
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            kclk_i,
  input  logic                            kdat_i,
  output logic                            kclk_en,
  output logic                            kdat_en,
  output logic [7:0]                      rx_dat_o,
  output logic                            rx_perr_o,
  output logic                            rx_vld_o,
  input  logic                            rx_rdy_i,
  output logic [$clog2(pRxDepth+1)-1:0]   rx_cnt_o,
  input  logic [7:0]                      tx_dat_i,
  input  logic                            tx_vld_i,
  output logic                            tx_rdy_o,
  output logic                            tx_done_o,
  output logic                            tx_nack_o,
  output logic                            tx_tmo_o,
  output logic                            ferr_o,
  output logic                            ovf_o,
  input  logic                            err_clr_i
);

  localparam int AW   = $clog2(pRxDepth);
  localparam int CW   = $clog2(pRxDepth + 1);
  localparam int FW   = (pFiltLen > 1) ? $clog2(pFiltLen) : 1;
  localparam int RTW  = (pRxBitTmo > 1) ? $clog2(pRxBitTmo) : 1;
  localparam int WDW  = (pTxTmo > 1) ? $clog2(pTxTmo) : 1;
  localparam int HMAX = (p100us > p5us) ? p100us : p5us;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

  typedef enum logic {R_IDLE, R_SHIFT} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_INH, T_REQ, T_REL, T_SHIFT, T_ACK, T_HI} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  // bit 0 carries the clock line, bit 1 the data line
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          kclk_f, kdat_f, kclk_d, fall, rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      kclk_d  <= 1'b1;
    end else begin
      sync1  <= {kdat_i, kclk_i};
      sync2  <= sync1;
      kclk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(pFiltLen - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign kclk_f = filt[0];
  assign kdat_f = filt[1];
  assign fall   = kclk_d & ~kclk_f;
  assign rise   = ~kclk_d & kclk_f;

  logic [8:0]     rx_sr;
  logic [3:0]     rx_bits;
  logic [RTW-1:0] rx_tmr;
  logic           rx_start, rx_bit, rx_stop, rx_abort;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    rx_bit   = 1'b0;
    rx_stop  = 1'b0;
    rx_abort = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (fall && tx_state == T_IDLE && !kdat_f) begin
          rx_start = 1'b1;
          rx_next  = R_SHIFT;
        end
      end
      R_SHIFT: begin
        if (fall) begin
          if (rx_bits == 4'd10) begin
            rx_stop = 1'b1;
            rx_next = R_IDLE;
          end else begin
            rx_bit = 1'b1;
          end
        end else if (rx_tmr == RTW'(pRxBitTmo - 1)) begin
          rx_abort = 1'b1;
          rx_next  = R_IDLE;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_sr   <= '0;
      rx_bits <= '0;
      rx_tmr  <= '0;
    end else begin
      if (rx_start) begin
        rx_bits <= 4'd1;
        rx_tmr  <= '0;
      end else if (rx_bit) begin
        rx_sr   <= {kdat_f, rx_sr[8:1]};
        rx_bits <= rx_bits + 4'd1;
        rx_tmr  <= '0;
      end else if (rx_state == R_SHIFT) begin
        rx_tmr <= rx_tmr + RTW'(1);
      end
    end
  end

  logic [8:0]  mem [pRxDepth];
  logic [AW:0] wr_ptr, rd_ptr, fill;
  logic [8:0]  head;
  logic        empty, full, pop, push, frame_ok, ovf_set, ferr_set;

  assign fill     = wr_ptr - rd_ptr;
  assign empty    = (fill == '0);
  assign full     = (fill == (AW+1)'(pRxDepth));
  assign pop      = rx_rdy_i && !empty;
  assign frame_ok = rx_stop && kdat_f;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the frame
  assign push     = frame_ok && (!full || pop);
  assign ovf_set  = frame_ok && full && !pop;
  assign ferr_set = (rx_stop && !kdat_f) || rx_abort;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {~^rx_sr, rx_sr[7:0]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ferr_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (err_clr_i)     ferr_o <= 1'b0;
      else if (ferr_set) ferr_o <= 1'b1;
      if (err_clr_i)     ovf_o <= 1'b0;
      else if (ovf_set)  ovf_o <= 1'b1;
    end
  end

  assign rx_vld_o  = !empty;
  assign rx_dat_o  = empty ? 8'h00 : head[7:0];
  assign rx_perr_o = !empty && head[8];
  assign rx_cnt_o  = CW'(fill);

  logic [9:0]     tx_sr;
  logic [3:0]     tx_bits;
  logic [WDW-1:0] wd;
  logic [HW-1:0]  tmr;
  logic           kdat_drv, tx_hs, wd_fire, tx_shift, tx_ack, tx_fin;

  assign tx_rdy_o = (tx_state == T_IDLE) && (rx_state == R_IDLE);
  assign tx_hs    = tx_vld_i && tx_rdy_o;
  assign wd_fire  = (tx_state != T_IDLE) && (wd == WDW'(pTxTmo - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tx_state <= T_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_shift = 1'b0;
    tx_ack   = 1'b0;
    tx_fin   = 1'b0;
    if (wd_fire) begin
      tx_next = T_IDLE;
    end else begin
      case (tx_state)
        T_IDLE:  if (tx_hs) tx_next = T_INH;
        T_INH:   if (tmr == HW'(p100us - 1)) tx_next = T_REQ;
        T_REQ:   if (tmr == HW'(p5us - 1)) tx_next = T_REL;
        T_REL:   tx_next = T_SHIFT;
        T_SHIFT: begin
          if (fall) begin
            tx_shift = 1'b1;
            if (tx_bits == 4'd9) tx_next = T_ACK;
          end
        end
        T_ACK: begin
          if (fall) begin
            tx_ack  = 1'b1;
            tx_next = T_HI;
          end
        end
        T_HI: begin
          if (rise) begin
            tx_fin  = 1'b1;
            tx_next = T_IDLE;
          end
        end
        default: tx_next = T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_sr     <= '0;
      tx_bits   <= '0;
      wd        <= '0;
      tmr       <= '0;
      kdat_drv  <= 1'b0;
      tx_done_o <= 1'b0;
      tx_nack_o <= 1'b0;
      tx_tmo_o  <= 1'b0;
    end else begin
      tx_done_o <= 1'b0;
      tx_tmo_o  <= 1'b0;
      if (tx_next != tx_state) tmr <= '0;
      else if (tx_state == T_INH || tx_state == T_REQ) tmr <= tmr + HW'(1);
      if (tx_hs) begin
        tx_sr   <= {1'b1, ~^tx_dat_i, tx_dat_i};
        tx_bits <= '0;
        wd      <= '0;
      end else if (tx_state != T_IDLE) begin
        wd <= wd + WDW'(1);
      end
      if (wd_fire) begin
        kdat_drv <= 1'b0;
        tx_tmo_o <= 1'b1;
      end else begin
        if (tx_state == T_INH && tx_next == T_REQ) kdat_drv <= 1'b1;
        if (tx_shift) begin
          kdat_drv <= ~tx_sr[0];
          tx_sr    <= {1'b0, tx_sr[9:1]};
          tx_bits  <= tx_bits + 4'd1;
        end
        if (tx_ack) tx_nack_o <= kdat_f;
        if (tx_fin) tx_done_o <= 1'b1;
      end
    end
  end

  assign kclk_en = (full && rx_state == R_IDLE) || tx_state == T_INH || tx_state == T_REQ;
  assign kdat_en = kdat_drv;

endmodule

// File: tb/tb_ps2_port_fifo.sv
// Bench for ps2_port_fifo: models the PS/2 device on wired-AND pads and scoreboards received bytes.
module tb_ps2_port_fifo;

  localparam int F     = 4;
  localparam int P5    = 5;
  localparam int P100  = 40;
  localparam int RTMO  = 200;
  localparam int TTMO  = 3000;
  localparam int DEPTH = 16;
  localparam int HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1, dev_dat = 1'b1, force_pad = 1'b0;
  logic       kclk_i, kdat_i, kclk_en, kdat_en;
  logic [7:0] rx_dat, tx_dat = 8'h00;
  logic       rx_perr, rx_vld, rx_rdy = 1'b0;
  logic [4:0] rx_cnt;
  logic       tx_vld = 1'b0, tx_rdy, tx_done, tx_nack, tx_tmo, ferr, ovf, err_clr = 1'b0;

  int checks = 0;
  int passed = 0;
  logic [8:0] sb_q [$];

  always #5 clk = ~clk;

  // open-collector pads; force_pad lets the device clock override a host inhibit
  assign kclk_i = force_pad ? dev_clk : (dev_clk & ~kclk_en);
  assign kdat_i = dev_dat & ~kdat_en;

  ps2_port_fifo #(
    .pClkFreq(40000000), .pRxDepth(DEPTH), .pFiltLen(F), .p5us(P5),
    .p100us(P100), .pRxBitTmo(RTMO), .pTxTmo(TTMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .kclk_i(kclk_i), .kdat_i(kdat_i),
    .kclk_en(kclk_en), .kdat_en(kdat_en),
    .rx_dat_o(rx_dat), .rx_perr_o(rx_perr), .rx_vld_o(rx_vld), .rx_rdy_i(rx_rdy),
    .rx_cnt_o(rx_cnt), .tx_dat_i(tx_dat), .tx_vld_i(tx_vld), .tx_rdy_o(tx_rdy),
    .tx_done_o(tx_done), .tx_nack_o(tx_nack), .tx_tmo_o(tx_tmo),
    .ferr_o(ferr), .ovf_o(ovf), .err_clr_i(err_clr)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    dev_dat = b;
    wait_clks(5);
    dev_clk = 1'b0;
    wait_clks(HALF);
    dev_clk = 1'b1;
    wait_clks(HALF - 5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip, b, 1'b0};
    for (int k = 0; k < nbits; k++) send_bit(f[k]);
    dev_dat = 1'b1;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [8:0] exp;
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_vld && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rx_vld) $display("[TB] FAIL %s_vld: rx_vld_o stayed 0 after %0d clocks, required 1", name, n);
    else if (sb_q.size() == 0) $display("[TB] FAIL %s_sb: DUT offers %h but no byte is expected", name, rx_dat);
    else begin
      exp = sb_q.pop_front();
      if ({rx_perr, rx_dat} !== exp)
        $display("[TB] FAIL %s_data: got perr=%b dat=%h, required perr=%b dat=%h", name, rx_perr, rx_dat, exp[8], exp[7:0]);
      else passed++;
    end
    rx_rdy = 1'b1;
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tx_dat = b;
    tx_vld = 1'b1;
    @(posedge clk);
    #1 tx_vld = 1'b0;
    checks++;
    if (tx_rdy !== 1'b0) $display("[TB] FAIL tx_rdy_drop: got %b, required 0", tx_rdy);
    else passed++;
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++;
    if ({kclk_en, kdat_en} !== 2'b00) $display("[TB] FAIL reset_lines: got %b, required 00", {kclk_en, kdat_en});
    else passed++;
    checks++;
    if ({rx_vld, rx_cnt, rx_dat, rx_perr} !== 15'h0) $display("[TB] FAIL reset_rx: got vld=%b cnt=%0d dat=%h perr=%b, required all 0", rx_vld, rx_cnt, rx_dat, rx_perr);
    else passed++;
    checks++;
    if ({tx_rdy, tx_done, tx_nack, tx_tmo} !== 4'b1000) $display("[TB] FAIL reset_tx: got %b, required 1000", {tx_rdy, tx_done, tx_nack, tx_tmo});
    else passed++;
    checks++;
    if ({ferr, ovf} !== 2'b00) $display("[TB] FAIL reset_err: got %b, required 00", {ferr, ovf});
    else passed++;
    rst = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_rx_basic();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    sb_q.push_back({1'b0, 8'h1C});
    checks++;
    if (rx_cnt !== 5'd1) $display("[TB] FAIL rx_basic_cnt: got %0d, required 1", rx_cnt);
    else passed++;
    pop_check("rx_basic");
    checks++;
    if (rx_vld !== 1'b0) $display("[TB] FAIL rx_basic_empty: rx_vld_o got %b, required 0", rx_vld);
    else passed++;
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    sb_q.push_back({1'b1, 8'h1C});
    checks++;
    if (ferr !== 1'b0) $display("[TB] FAIL parity_ferr: got %b, required 0", ferr);
    else passed++;
    pop_check("parity_err");
  endtask

  task automatic test_framing_err();
    send_frame(8'hA5, 1'b0, 1'b0, 11);
    checks++;
    if ({ferr, rx_cnt} !== {1'b1, 5'd0}) $display("[TB] FAIL framing: got ferr=%b cnt=%0d, required ferr=1 cnt=0", ferr, rx_cnt);
    else passed++;
    clear_errors();
    checks++;
    if (ferr !== 1'b0) $display("[TB] FAIL framing_clr: got %b, required 0", ferr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    bytes = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 4; i++) begin
      send_frame(bytes[i], 1'b0, 1'b1, 11);
      sb_q.push_back({1'b0, bytes[i]});
    end
    checks++;
    if (rx_cnt !== 5'd4) $display("[TB] FAIL b2b_cnt: got %0d, required 4", rx_cnt);
    else passed++;
    for (int i = 0; i < 4; i++) pop_check("b2b");
    checks++;
    if (rx_vld !== 1'b0) $display("[TB] FAIL b2b_empty: rx_vld_o got %b, required 0", rx_vld);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b0, 1'b1, 11);
      sb_q.push_back({1'b0, b});
    end
    checks++;
    if ({kclk_en, rx_cnt} !== {1'b1, 5'd16}) $display("[TB] FAIL ovf_full: got kclk_en=%b cnt=%0d, required 1 16", kclk_en, rx_cnt);
    else passed++;
    force_pad = 1'b1;
    wait_clks(20);
    send_frame(8'h77, 1'b0, 1'b1, 11);
    force_pad = 1'b0;
    wait_clks(5);
    checks++;
    if ({ovf, rx_cnt} !== {1'b1, 5'd16}) $display("[TB] FAIL ovf_drop: got ovf=%b cnt=%0d, required 1 16", ovf, rx_cnt);
    else passed++;
    pop_check("ovf_first");
    checks++;
    if ({kclk_en, rx_cnt} !== {1'b0, 5'd15}) $display("[TB] FAIL ovf_release: got kclk_en=%b cnt=%0d, required 0 15", kclk_en, rx_cnt);
    else passed++;
    clear_errors();
    checks++;
    if (ovf !== 1'b0) $display("[TB] FAIL ovf_clr: got %b, required 0", ovf);
    else passed++;
    for (int i = 0; i < DEPTH - 1; i++) pop_check("ovf_drain");
  endtask

  task automatic test_bit_timeout();
    send_frame(8'h3C, 1'b0, 1'b1, 5);
    wait_clks(100);
    checks++;
    if ({ferr, tx_rdy} !== 2'b00) $display("[TB] FAIL tmo_early: got ferr=%b tx_rdy=%b, required 0 0", ferr, tx_rdy);
    else passed++;
    wait_clks(150);
    checks++;
    if ({ferr, tx_rdy, rx_cnt} !== {2'b11, 5'd0}) $display("[TB] FAIL tmo_abort: got ferr=%b tx_rdy=%b cnt=%0d, required 1 1 0", ferr, tx_rdy, rx_cnt);
    else passed++;
    clear_errors();
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    sb_q.push_back({1'b0, 8'h3C});
    pop_check("tmo_recover");
  endtask

  task automatic test_tx(input logic [7:0] b, input logic ack);
    logic [9:0] bits;
    int n_inh, n_req, n;
    bits = {1'b1, ~^b, b};
    start_tx(b);
    n_inh = 0;
    @(negedge clk);
    while (kclk_en && !kdat_en && n_inh < 1000) begin
      n_inh++;
      @(negedge clk);
    end
    n_req = 0;
    while (kclk_en && kdat_en && n_req < 1000) begin
      n_req++;
      @(negedge clk);
    end
    checks++;
    if (n_inh !== P100) $display("[TB] FAIL tx_inhibit_len: got %0d clocks, required %0d", n_inh, P100);
    else passed++;
    checks++;
    if (n_req !== P5) $display("[TB] FAIL tx_req_len: got %0d clocks, required %0d", n_req, P5);
    else passed++;
    checks++;
    if ({kclk_en, kdat_en} !== 2'b01) $display("[TB] FAIL tx_start_bit: got kclk_en=%b kdat_en=%b, required 0 1", kclk_en, kdat_en);
    else passed++;
    wait_clks(10);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      wait_clks(HALF);
      checks++;
      if (kdat_en !== ~bits[k]) $display("[TB] FAIL tx_bit%0d: kdat_en got %b, required %b", k, kdat_en, ~bits[k]);
      else passed++;
      dev_clk = 1'b1;
      wait_clks(HALF);
    end
    dev_dat = ~ack;
    wait_clks(10);
    dev_clk = 1'b0;
    wait_clks(HALF);
    dev_clk = 1'b1;
    n = 0;
    @(posedge clk);
    #1;
    while (!tx_done && !tx_tmo && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if ({tx_done, tx_tmo, tx_nack} !== {2'b10, ~ack}) $display("[TB] FAIL tx_done: got done=%b tmo=%b nack=%b, required 1 0 %b", tx_done, tx_tmo, tx_nack, ~ack);
    else passed++;
    dev_dat = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_tx_timeout();
    int cycles;
    logic saw_done;
    start_tx(8'hFF);
    cycles = 0;
    saw_done = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (tx_done) saw_done = 1'b1;
    end while (!tx_tmo && cycles < TTMO + 100);
    checks++;
    if (cycles !== TTMO) $display("[TB] FAIL wd_time: tx_tmo_o after %0d clocks, required %0d", cycles, TTMO);
    else passed++;
    checks++;
    if ({kclk_en, kdat_en, tx_rdy, saw_done} !== 4'b0010) $display("[TB] FAIL wd_release: got kclk_en=%b kdat_en=%b tx_rdy=%b done=%b, required 0 0 1 0", kclk_en, kdat_en, tx_rdy, saw_done);
    else passed++;
    wait_clks(20);
  endtask

  task automatic test_reset_mid_tx();
    int n;
    send_frame(8'h42, 1'b0, 1'b1, 11);
    start_tx(8'h55);
    n = 0;
    @(negedge clk);
    while (!kdat_en && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({kclk_en, kdat_en, rx_cnt} !== {2'b11, 5'd1}) $display("[TB] FAIL rst_pre: got kclk_en=%b kdat_en=%b cnt=%0d, required 1 1 1", kclk_en, kdat_en, rx_cnt);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({kclk_en, kdat_en, rx_vld, rx_cnt} !== 8'h00) $display("[TB] FAIL rst_release: got kclk_en=%b kdat_en=%b vld=%b cnt=%0d, required all 0", kclk_en, kdat_en, rx_vld, rx_cnt);
    else passed++;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(20);
    checks++;
    if (tx_rdy !== 1'b1) $display("[TB] FAIL rst_rdy: got %b, required 1", tx_rdy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_parity_err();
    test_framing_err();
    test_back_to_back();
    test_overflow();
    test_bit_timeout();
    test_tx(8'hED, 1'b1);
    test_tx(8'h3A, 1'b0);
    test_tx_timeout();
    test_reset_mid_tx();
    checks++;
    if (sb_q.size() != 0) $display("[TB] FAIL sb_leftover: %0d expected bytes never produced, required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
